// File: rtl/bf128_key_loader.sv
// rtl/bf128_key_loader.sv - packs a streamed 32-bit user key into key0..key7 and runs the skeygen2 handshake
module bf128_key_loader #(
    parameter int MAX_KEY_WORDS = 8,
    parameter int TIMEOUT_CYC   = 4096
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        key_start_i,
    input  logic [3:0]  key_len_in_i,
    input  logic        key_word_valid_i,
    input  logic [31:0] key_word_i,
    output logic        key_word_ready_o,
    output logic [63:0] key0_o,
    output logic [63:0] key1_o,
    output logic [63:0] key2_o,
    output logic [63:0] key3_o,
    output logic [63:0] key4_o,
    output logic [63:0] key5_o,
    output logic [63:0] key6_o,
    output logic [63:0] key7_o,
    output logic [3:0]  key_length_o,
    output logic        enable_o,
    input  logic        skey_ready_i,
    output logic        keys_ready_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [3:0]    MAX_LEN   = 4'(MAX_KEY_WORDS);
    localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_GEN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    len_q, len_d;
    logic [3:0]    wcnt_q, wcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          err_q, err_d;
    logic [63:0]   key_q [MAX_KEY_WORDS];
    logic [63:0]   key_d [MAX_KEY_WORDS];

    logic start_ok;
    logic last_word;

    assign start_ok  = (key_len_in_i != 4'd0) && (key_len_in_i <= MAX_LEN);
    assign last_word = ({1'b0, wcnt_q} == ({len_q, 1'b0} - 5'd1));

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        tcnt_d  = tcnt_q;
        err_d   = 1'b0;
        for (int i = 0; i < MAX_KEY_WORDS; i++) key_d[i] = key_q[i];

        case (state_q)
            S_IDLE, S_DONE: begin
                if (key_start_i) begin
                    if (start_ok) begin
                        len_d   = key_len_in_i;
                        wcnt_d  = 4'd0;
                        tcnt_d  = '0;
                        state_d = S_LOAD;
                        for (int i = 0; i < MAX_KEY_WORDS; i++) key_d[i] = 64'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                // Words arrive most significant first: even index fills the upper half.
                if (key_word_valid_i) begin
                    if (wcnt_q[0]) key_d[wcnt_q[3:1]][31:0]  = key_word_i;
                    else           key_d[wcnt_q[3:1]][63:32] = key_word_i;
                    wcnt_d = wcnt_q + 4'd1;
                    if (last_word) begin
                        tcnt_d  = '0;
                        state_d = S_GEN;
                    end
                end
            end
            S_GEN: begin
                // skey_ready takes priority over a timeout landing on the same cycle.
                if (skey_ready_i) begin
                    state_d = S_DONE;
                end else if (tcnt_q == TOUT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            len_q   <= 4'd0;
            wcnt_q  <= 4'd0;
            tcnt_q  <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < MAX_KEY_WORDS; i++) key_q[i] <= 64'd0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
            for (int i = 0; i < MAX_KEY_WORDS; i++) key_q[i] <= key_d[i];
        end
    end

    assign key_word_ready_o = (state_q == S_LOAD);
    assign enable_o         = (state_q == S_GEN);
    assign keys_ready_o     = (state_q == S_DONE);
    assign busy_o           = (state_q == S_LOAD) || (state_q == S_GEN);
    assign err_o            = err_q;
    assign key_length_o     = len_q;

    assign key0_o = key_q[0];
    assign key1_o = key_q[1];
    assign key2_o = key_q[2];
    assign key3_o = key_q[3];
    assign key4_o = key_q[4];
    assign key5_o = key_q[5];
    assign key6_o = key_q[6];
    assign key7_o = key_q[7];

endmodule

// File: tb/tb_bf128_key_loader.sv
// tb/tb_bf128_key_loader.sv - randomized self-checking bench for bf128_key_loader
module tb_bf128_key_loader;

    localparam int TO = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_start;
    logic [3:0]  key_len;
    logic        kw_valid;
    logic [31:0] kw;
    logic        kw_ready;
    logic [63:0] k [8];
    logic [3:0]  key_length;
    logic        enable;
    logic        skey_ready;
    logic        keys_ready;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;

    logic [31:0] wq [$];
    logic [63:0] exp_key [8];

    always #5 clk = ~clk;

    bf128_key_loader #(.MAX_KEY_WORDS(8), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .key_start_i(key_start), .key_len_in_i(key_len),
        .key_word_valid_i(kw_valid), .key_word_i(kw), .key_word_ready_o(kw_ready),
        .key0_o(k[0]), .key1_o(k[1]), .key2_o(k[2]), .key3_o(k[3]),
        .key4_o(k[4]), .key5_o(k[5]), .key6_o(k[6]), .key7_o(k[7]),
        .key_length_o(key_length), .enable_o(enable), .skey_ready_i(skey_ready),
        .keys_ready_o(keys_ready), .busy_o(busy), .err_o(err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected key: pairs of words, first word of each pair is the high half.
    task automatic build_model(input int len);
        for (int j = 0; j < 8; j++)
            exp_key[j] = (j < len) ? {wq[2*j], wq[2*j+1]} : 64'd0;
    endtask

    task automatic chk_keys(input string tag);
        for (int j = 0; j < 8; j++) chk($sformatf("%s_key%0d", tag, j), k[j], exp_key[j]);
    endtask

    task automatic rand_words(input int len);
        wq.delete();
        for (int i = 0; i < 2*len; i++) wq.push_back($urandom);
    endtask

    task automatic load(input int len, input int gap);
        int i;
        int guard;
        key_len   = 4'(len);
        key_start = 1'b1;
        step();
        key_start = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_len", 64'(key_length), 64'(len));
        chk("start_cleared", k[0], 64'd0);
        i = 0;
        guard = 0;
        while (i < 2*len && guard < 2000) begin
            if (!kw_ready) break;
            kw_valid = (gap == 0) || ($urandom_range(0, gap) == 0);
            kw = kw_valid ? wq[i] : $urandom;
            step();
            if (kw_valid) i++;
            guard++;
        end
        kw_valid = 1'b0;
        chk("load_count", 64'(i), 64'(2*len));
        chk("gen_enable", 64'(enable), 64'd1);
        chk("gen_ready_low", 64'(kw_ready), 64'd0);
        chk("gen_busy", 64'(busy), 64'd1);
        build_model(len);
        chk_keys("load");
    endtask

    task automatic gen(input int n);
        skey_ready = 1'b0;
        repeat (n) step();
        chk("gen_hold_en", 64'(enable), 64'd1);
        chk("gen_hold_kr", 64'(keys_ready), 64'd0);
        skey_ready = 1'b1;
        step();
        skey_ready = 1'b0;
        chk("done_en", 64'(enable), 64'd0);
        chk("done_kr", 64'(keys_ready), 64'd1);
        chk("done_busy", 64'(busy), 64'd0);
        chk_keys("done");
    endtask

    initial begin
        int c;
        int len;
        rst = 1'b1; key_start = 1'b0; key_len = 4'd0;
        kw_valid = 1'b0; kw = 32'd0; skey_ready = 1'b0;
        step();
        step();
        chk("rst_en", 64'(enable), 64'd0);
        chk("rst_rdy", 64'(kw_ready), 64'd0);
        chk("rst_kr", 64'(keys_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_len", 64'(key_length), 64'd0);
        for (int j = 0; j < 8; j++) exp_key[j] = 64'd0;
        chk_keys("rst");
        rst = 1'b0;
        step();

        // Directed len=4 load with known words
        wq = '{32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210,
               32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
        load(4, 0);
        chk("t1_key0", k[0], 64'h0123456789ABCDEF);
        chk("t1_key3", k[3], 64'h8899AABBCCDDEEFF);
        gen(20);

        // Illegal length from DONE: err pulse, DONE retained
        key_len = 4'd9; key_start = 1'b1;
        step();
        key_start = 1'b0;
        chk("done_bad_err", 64'(err), 64'd1);
        chk("done_bad_kr", 64'(keys_ready), 64'd1);
        step();
        chk("done_bad_err_pulse", 64'(err), 64'd0);
        skey_ready = 1'b1;
        step();
        skey_ready = 1'b0;
        chk("done_skey_ignored_en", 64'(enable), 64'd0);
        chk("done_skey_ignored_kr", 64'(keys_ready), 64'd1);
        chk_keys("done_hold");

        // Random lengths with random valid gaps
        for (int r = 0; r < 8; r++) begin
            len = (r == 0) ? 1 : (r == 1) ? 8 : int'($urandom_range(1, 8));
            rand_words(len);
            load(len, 3);
            gen(int'($urandom_range(0, 30)));
        end

        // Timeout with skey_ready never returning
        rand_words(2);
        load(2, 0);
        c = 0;
        while (!err && c < TO + 20) begin
            step();
            c++;
        end
        chk("to_cycles", 64'(c), 64'(TO));
        chk("to_en", 64'(enable), 64'd0);
        chk("to_busy", 64'(busy), 64'd0);
        chk("to_kr", 64'(keys_ready), 64'd0);
        step();
        chk("to_err_pulse", 64'(err), 64'd0);

        // Illegal lengths from IDLE
        for (int j = 0; j < 3; j++) begin
            key_len = (j == 0) ? 4'd0 : (j == 1) ? 4'd9 : 4'd15;
            key_start = 1'b1;
            step();
            key_start = 1'b0;
            chk($sformatf("idle_bad%0d_err", j), 64'(err), 64'd1);
            chk($sformatf("idle_bad%0d_rdy", j), 64'(kw_ready), 64'd0);
            chk($sformatf("idle_bad%0d_busy", j), 64'(busy), 64'd0);
            step();
            chk($sformatf("idle_bad%0d_pulse", j), 64'(err), 64'd0);
        end

        // skey_ready on the final timeout cycle wins
        rand_words(3);
        load(3, 0);
        repeat (TO - 1) step();
        chk("tie_still_gen", 64'(enable), 64'd1);
        skey_ready = 1'b1;
        step();
        skey_ready = 1'b0;
        chk("tie_kr", 64'(keys_ready), 64'd1);
        chk("tie_err", 64'(err), 64'd0);

        // Reset mid-load discards the partial key
        rand_words(8);
        key_len = 4'd8; key_start = 1'b1;
        step();
        key_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            kw_valid = 1'b1; kw = wq[i];
            step();
        end
        kw_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_rdy", 64'(kw_ready), 64'd0);
        chk("mid_rst_len", 64'(key_length), 64'd0);
        chk("mid_rst_kr", 64'(keys_ready), 64'd0);
        chk("mid_rst_en", 64'(enable), 64'd0);
        for (int j = 0; j < 8; j++) exp_key[j] = 64'd0;
        chk_keys("mid_rst");
        load(8, 2);
        gen(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
